// File: rtl/isqrt_responder.sv
// Sequential 32-bit integer square root (one result bit per cycle) behind a small
// request FIFO, so back-to-back callers are queued rather than lost.
module isqrt_responder #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy,
   output logic        ovf
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]  state;
   logic [31:0] op;
   logic [15:0] rem;
   logic [15:0] root;
   logic [3:0]  cnt;

   logic [31:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push;
   logic [31:0] head;

   logic [17:0] r2;
   logic [17:0] t;
   logic        take;
   logic [15:0] root_nxt;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_OUT));
   assign push       = x_vld && (!fifo_full || pop);
   assign head       = mem[rd_ptr[AW-1:0]];

   assign r2       = {rem, op[31:30]};
   assign t        = {root, 2'b01};
   assign take     = (r2 >= t);
   assign root_nxt = {root[14:0], take};

   assign busy = !fifo_empty || (state != S_IDLE);

   // NOTE: storage array has no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= x;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // sees pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (x_vld && !push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         op    <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
         y     <= '0;
         y_vld <= 1'b0;
      end else begin
         y_vld <= 1'b0;
         case (state)
            S_IDLE, S_OUT: begin
               if (pop) begin
                  op    <= head;
                  rem   <= '0;
                  root  <= '0;
                  cnt   <= '0;
                  state <= S_CALC;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               // Remainder stays within 16 bits until the last step, which is discarded.
               rem  <= take ? 16'(r2 - t) : r2[15:0];
               root <= root_nxt;
               op   <= {op[29:0], 2'b00};
               cnt  <= cnt + 1'b1;
               if (cnt == 4'd15) begin
                  y     <= root_nxt;
                  y_vld <= 1'b1;
                  state <= S_OUT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isqrt_responder.sv
// Self-checking bench for isqrt_responder: directed corners plus randomized
// requests compared with a behavioural floor(sqrt) and queue-timing model.
module tb_isqrt_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;
   int n_results = 0;

   typedef struct {
      int y;
      int due;
   } exp_t;

   exp_t expq[$];
   int   starts[$];
   int   last_done = -100;
   bit   ovf_exp   = 1'b0;
   bit   prev_vld  = 1'b0;

   isqrt_responder #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y),
      .busy  (busy),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   function automatic int isqrt(input logic [31:0] v);
      longint lo = 0;
      longint hi = 65535;
      longint mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(v)) lo = mid;
         else hi = mid - 1;
      end
      return int'(lo);
   endfunction

   // Queue model: a job starts one edge after it is pushed or one edge after the
   // previous result, whichever is later, and finishes 16 edges after starting.
   // A push at edge e fits if fewer than DEPTH earlier jobs are still waiting after e.
   task automatic model_push(input int yexp, input int e);
      int st;
      while (starts.size() > 0 && starts[0] <= e) void'(starts.pop_front());
      if (starts.size() < DEPTH) begin
         st = (e + 1 > last_done + 1) ? e + 1 : last_done + 1;
         last_done = st + 16;
         starts.push_back(st);
         expq.push_back('{y: yexp, due: last_done});
      end else begin
         ovf_exp = 1'b1;
      end
   endtask

   task automatic model_reset();
      expq.delete();
      starts.delete();
      last_done = -100;
      ovf_exp   = 1'b0;
   endtask

   // Called at a falling edge; the request is sampled by the next rising edge.
   task automatic send_exp(input logic [31:0] v, input int yexp);
      x     = v;
      x_vld = 1'b1;
      model_push(yexp, edge_n + 1);
      @(negedge clk);
      x_vld = 1'b0;
   endtask

   task automatic send(input logic [31:0] v);
      send_exp(v, isqrt(v));
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (expq.size() == 0 && !busy) break;
         @(negedge clk);
      end
      check("drain", expq.size(), 0);
      check("busy_idle", busy, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!rst && y_vld) begin
         n_results++;
         check("vld_pulse", prev_vld, 1'b0);
         if (expq.size() == 0) begin
            check("unexp_vld", y_vld, 1'b0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("y", y, e.y);
            check("latency_edge", edge_n, e.due);
         end
      end
      prev_vld = y_vld;
   end

   initial begin
      int base;
      int gap;
      logic [31:0] v;

      rst   = 1'b1;
      x_vld = 1'b0;
      x     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_y_vld", y_vld, 1'b0);
      check("rst_y", y, 16'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);

      // Corner values, one at a time.
      send_exp(32'd0, 0);  wait_drain(40);
      send_exp(32'd1, 1);  wait_drain(40);
      send_exp(32'd15, 3); wait_drain(40);
      send_exp(32'd16, 4); wait_drain(40);

      // Range ends.
      send_exp(32'hFFFF_FFFF, 16'hFFFF); wait_drain(40);
      send_exp(32'd1000000, 1000);       wait_drain(40);
      send_exp(32'hFFFE_0001, 16'hFFFF); wait_drain(40);
      send_exp(32'hFFFE_0000, 16'hFFFE); wait_drain(40);

      // Back-to-back queueing: results due at edges base+17, +34, +51.
      base = edge_n + 1;
      send_exp(32'd4, 2);
      send_exp(32'd9, 3);
      send_exp(32'd2, 1);
      while (edge_n < base + 51) @(negedge clk);
      check("b2b_busy_last_out", busy, 1'b1);
      @(negedge clk);
      check("b2b_busy_fall", busy, 1'b0);
      wait_drain(20);

      // Overflow: six consecutive pushes into a 4-deep FIFO; the sixth is lost.
      n_results = 0;
      for (int i = 1; i <= 6; i++) send(32'(i));
      check("ovf_set", ovf, 1'b1);
      check("ovf_model", ovf, ovf_exp);
      wait_drain(200);
      check("ovf_results", n_results, 5);
      check("ovf_sticky", ovf, 1'b1);

      // Reset mid-operation discards the in-flight request.
      base = edge_n + 1;
      send(32'd100);
      while (edge_n < base + 9) @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_results = 0;
      repeat (40) @(negedge clk);
      check("rst_mid_results", n_results, 0);
      check("rst_mid_y", y, 16'h0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ovf", ovf, 1'b0);
      send_exp(32'd49, 7);
      wait_drain(40);

      // Random operands with gaps of at least 17 cycles: no loss expected.
      for (int i = 0; i < 2000; i++) begin
         v = $urandom();
         if (i % 8 == 0) v = v >> $urandom_range(31, 0);
         send(v);
         gap = $urandom_range(24, 17);
         repeat (gap - 1) @(negedge clk);
      end
      wait_drain(60);
      check("rand_ovf", ovf, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
